// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: generic valid/ready stage register with a two-entry skid
// buffer for the LC-3b pipeline. in_ready is decoded from the state register
// alone, so no combinational ready path crosses the stage. Synchronous flush
// turns held entries into bubbles.
// Optional feature: define PIPE_STATS_EN to build a saturating back-pressure
// counter on stall_cnt; otherwise stall_cnt is tied to zero.
module pipe_stage_skid #(
  parameter int PAYLOAD_W = 16,
  parameter int STAT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data,
  input  logic                 flush,
  output logic [1:0]           level,
  output logic [STAT_W-1:0]    stall_cnt
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                 state_p1;
  state_t                 state_nxt;
  logic [PAYLOAD_W-1:0]   main_p1;
  logic [PAYLOAD_W-1:0]   skid_p1;
  logic                   in_fire;
  logic                   out_fire;
  logic                   load_main_in;
  logic                   load_main_skid;
  logic                   load_skid;

  assign in_ready  = (state_p1 != FULL);
  assign out_valid = (state_p1 != EMPTY);
  assign level     = state_p1;
  assign out_data  = main_p1;

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Next-state and data-load decode; flush overrides everything and blocks
  // the capture of a payload offered in the same cycle.
  always_comb begin
    state_nxt      = state_p1;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_p1)
      EMPTY: begin
        if (in_fire) begin
          load_main_in = 1'b1;
          state_nxt    = BUSY;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          load_main_in = 1'b1;
        end else if (in_fire) begin
          load_skid = 1'b1;
          state_nxt = FULL;
        end else if (out_fire) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          load_main_skid = 1'b1;
          state_nxt      = BUSY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    if (flush) begin
      state_nxt      = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  // State register; reset drops all entries immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1 <= EMPTY;
    end else begin
      state_p1 <= state_nxt;
    end
  end

  // Main and skid entries; out_data must read zero while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_p1 <= '0;
      skid_p1 <= '0;
    end else begin
      if (load_main_in) begin
        main_p1 <= in_data;
      end else if (load_main_skid) begin
        main_p1 <= skid_p1;
      end
      if (load_skid) begin
        skid_p1 <= in_data;
      end
    end
  end

`ifdef PIPE_STATS_EN
  logic [STAT_W-1:0] stall_p1;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

  // Count cycles where a valid payload is refused downstream; flush leaves it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_p1 <= '0;
    end else if (out_valid && !out_ready) begin
      stall_p1 <= sat_inc(stall_p1);
    end
  end

  assign stall_cnt = stall_p1;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid with a scoreboard queue: payloads are
// pushed when accepted and popped/compared when the stage hands them on.
module tb_pipe_stage_skid;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        flush;
  logic [1:0]  level;
  logic [3:0]  stall_cnt;

  int checks = 0;
  int errors = 0;
  logic [15:0] sb[$];

`ifdef PIPE_STATS_EN
  localparam logic [3:0] STALL_MID = 4'd5;
  localparam logic [3:0] STALL_SAT = 4'd15;
`else
  localparam logic [3:0] STALL_MID = 4'd0;
  localparam logic [3:0] STALL_SAT = 4'd0;
`endif

  pipe_stage_skid #(.PAYLOAD_W(16), .STAT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .level     (level),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard bookkeeping for the coming edge, then advance one cycle.
  task automatic step();
    logic [15:0] exp;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_out", 32'(out_data), 32'hDEAD_BEEF);
      end else begin
        exp = sb.pop_front();
        chk("sb_out_data", 32'(out_data), 32'(exp));
      end
    end
    if (flush) sb.delete();
    else if (in_valid && in_ready) sb.push_back(in_data);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_level",     32'(level),     32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_stall",     32'(stall_cnt), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: streaming with out_ready high
    out_ready = 1'b1; in_valid = 1'b1;
    in_data = 16'h1111; step();
    chk("s1_valid", 32'(out_valid), 32'd1);
    chk("s1_level", 32'(level), 32'd1);
    chk("s1_data",  32'(out_data), 32'h1111);
    in_data = 16'h2222; step();
    chk("s1_level2", 32'(level), 32'd1);
    chk("s1_ready2", 32'(in_ready), 32'd1);
    chk("s1_data2",  32'(out_data), 32'h2222);
    in_data = 16'h3333; step();
    chk("s1_data3", 32'(out_data), 32'h3333);
    in_valid = 1'b0; step();
    chk("s1_drain_level", 32'(level), 32'd0);
    chk("s1_drain_valid", 32'(out_valid), 32'd0);

    // 2: back-pressure fill, third push refused
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 16'hAAAA; step();
    in_data = 16'hBBBB; step();
    chk("s2_level_full", 32'(level), 32'd2);
    chk("s2_ready_low",  32'(in_ready), 32'd0);
    in_data = 16'hCCCC; step();
    chk("s2_level_hold", 32'(level), 32'd2);
    chk("s2_head",       32'(out_data), 32'hAAAA);
    in_valid = 1'b0; out_ready = 1'b1; step();
    chk("s2_level_1", 32'(level), 32'd1);
    chk("s2_next",    32'(out_data), 32'hBBBB);
    step();
    chk("s2_level_0", 32'(level), 32'd0);
    chk("s2_sb_empty", 32'(sb.size()), 32'd0);

    // 3: flush from FULL with a simultaneous push
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 16'h7777; step();
    in_data = 16'h8888; step();
    chk("s3_level_full", 32'(level), 32'd2);
    flush = 1'b1; in_data = 16'h5555; step();
    flush = 1'b0; in_valid = 1'b0;
    chk("s3_valid", 32'(out_valid), 32'd0);
    chk("s3_level", 32'(level), 32'd0);
    chk("s3_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h6666; step();
    in_valid = 1'b0;
    chk("s3_single", 32'(out_data), 32'h6666);
    chk("s3_level1", 32'(level), 32'd1);
    step();
    chk("s3_level0", 32'(level), 32'd0);

    // 4: asynchronous reset between edges while FULL
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 16'h9999; step();
    in_data = 16'hABCD; step();
    in_valid = 1'b0;
    chk("s4_level_full", 32'(level), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("s4_valid", 32'(out_valid), 32'd0);
    chk("s4_ready", 32'(in_ready), 32'd1);
    chk("s4_data",  32'(out_data), 32'd0);
    chk("s4_level", 32'(level), 32'd0);
    sb.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // 5: stall counter saturation, flush immunity, reset clear
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h1234; step();
    in_valid = 1'b0;
    repeat (5) step();
    chk("s5_stall_mid", 32'(stall_cnt), 32'(STALL_MID));
    repeat (15) step();
    chk("s5_stall_sat", 32'(stall_cnt), 32'(STALL_SAT));
    flush = 1'b1; step(); flush = 1'b0;
    chk("s5_stall_flush", 32'(stall_cnt), 32'(STALL_SAT));
    chk("s5_flush_level", 32'(level), 32'd0);
    rst_n = 1'b0; #1;
    chk("s5_stall_rst", 32'(stall_cnt), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    chk("end_sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
